// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Purpose  : ID/EX pipeline register feeding the EX-stage ALU, with
//             valid/ready handshake, flush, and EX/MEM + MEM/WB forwarding.
//             Forwarding and stall-time operand refresh exist only when
//             ID_EX_FWD_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 4,
    parameter int RADDR_W = 5,
    parameter int IMM_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RADDR_W-1:0] rs_addr,
    input  logic [RADDR_W-1:0] rt_addr,
    input  logic [DATA_W-1:0]  rs_data,
    input  logic [DATA_W-1:0]  rt_data,
    input  logic [IMM_W-1:0]   imm,
    input  logic               use_imm,
    input  logic [SEL_W-1:0]   sel_in,
    input  logic [RADDR_W-1:0] rd_in,
    input  logic               wr_en_in,
    input  logic               flush,
    input  logic               exmem_wr,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]  exmem_res,
    input  logic               memwb_wr,
    input  logic [RADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]  memwb_data,
    output logic [DATA_W-1:0]  A,
    output logic [DATA_W-1:0]  B,
    output logic [SEL_W-1:0]   Sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RADDR_W-1:0] rd_out,
    output logic               wr_en_out
);

    logic               r_out_valid;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic [SEL_W-1:0]   r_sel;
    logic [RADDR_W-1:0] r_rd;
    logic               r_wr_en;
    logic [RADDR_W-1:0] r_rs_addr;
    logic [RADDR_W-1:0] r_rt_addr;
    logic               r_use_imm;

    logic               w_capture;
    logic [DATA_W-1:0]  w_imm_ext;
    logic [DATA_W-1:0]  w_cap_a;
    logic [DATA_W-1:0]  w_cap_b;
    logic               w_rs_ex, w_rs_wb, w_rt_ex, w_rt_wb;
    logic               w_hrs_ex, w_hrs_wb, w_hrt_ex, w_hrt_wb;

`ifdef ID_EX_FWD_EN
    function automatic logic hit(input logic               wr,
                                 input logic [RADDR_W-1:0] dst,
                                 input logic [RADDR_W-1:0] addr);
        return wr && (dst == addr) && (addr != '0);
    endfunction

    assign w_rs_ex  = hit(exmem_wr, exmem_rd, rs_addr);
    assign w_rs_wb  = hit(memwb_wr, memwb_rd, rs_addr);
    assign w_rt_ex  = hit(exmem_wr, exmem_rd, rt_addr);
    assign w_rt_wb  = hit(memwb_wr, memwb_rd, rt_addr);
    assign w_hrs_ex = hit(exmem_wr, exmem_rd, r_rs_addr);
    assign w_hrs_wb = hit(memwb_wr, memwb_rd, r_rs_addr);
    assign w_hrt_ex = hit(exmem_wr, exmem_rd, r_rt_addr);
    assign w_hrt_wb = hit(memwb_wr, memwb_rd, r_rt_addr);
`else
    // Without forwarding the hazard unit inserts bubbles; bypass inputs are dead.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{exmem_wr, exmem_rd, memwb_wr, memwb_rd,
                            r_rs_addr, r_rt_addr, r_use_imm};
    assign w_rs_ex  = 1'b0;
    assign w_rs_wb  = 1'b0;
    assign w_rt_ex  = 1'b0;
    assign w_rt_wb  = 1'b0;
    assign w_hrs_ex = 1'b0;
    assign w_hrs_wb = 1'b0;
    assign w_hrt_ex = 1'b0;
    assign w_hrt_wb = 1'b0;
`endif

    assign in_ready  = !r_out_valid || out_ready;
    assign w_capture = in_valid && in_ready;
    assign w_imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    // EX/MEM outranks MEM/WB because it holds the younger result.
    always_comb begin
        w_cap_a = rs_data;
        w_cap_b = rt_data;
        if (rs_addr == '0)  w_cap_a = '0;
        else if (w_rs_ex)   w_cap_a = exmem_res;
        else if (w_rs_wb)   w_cap_a = memwb_data;
        if (use_imm)        w_cap_b = w_imm_ext;
        else if (rt_addr == '0) w_cap_b = '0;
        else if (w_rt_ex)   w_cap_b = exmem_res;
        else if (w_rt_wb)   w_cap_b = memwb_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sel       <= '0;
            r_rd        <= '0;
            r_wr_en     <= 1'b0;
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_use_imm   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_sel       <= '0;
            r_wr_en     <= 1'b0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_a         <= w_cap_a;
            r_b         <= w_cap_b;
            r_sel       <= sel_in;
            r_rd        <= rd_in;
            r_wr_en     <= wr_en_in;
            r_rs_addr   <= rs_addr;
            r_rt_addr   <= rt_addr;
            r_use_imm   <= use_imm;
        end else if (r_out_valid && !out_ready) begin
            // Stalled: keep held operands current with in-flight writebacks.
            if (w_hrs_ex)      r_a <= exmem_res;
            else if (w_hrs_wb) r_a <= memwb_data;
            if (!r_use_imm) begin
                if (w_hrt_ex)      r_b <= exmem_res;
                else if (w_hrt_wb) r_b <= memwb_data;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_sel       <= '0;
            r_wr_en     <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign A         = r_a;
    assign B         = r_b;
    assign Sel       = r_sel;
    assign rd_out    = r_rd;
    assign wr_en_out = r_wr_en;

endmodule
`default_nettype wire
